// File: rtl/arith_pkg.sv
// Shared opcode encoding and constants for the arith_unit datapath.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // All-ones quotient for B=0; users take the low WIDTH bits (WIDTH <= 64).
  localparam logic [63:0] DIV_BY_ZERO = '1;

endpackage

// File: rtl/arith_div.sv
// Combinational unsigned restoring divider: quotient only, all ones on B=0.
module arith_div
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient
);

  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_num;
  logic [WIDTH-1:0] w_quo;

  // One restoring step per dividend bit, MSB first; the dividend is shifted
  // out of w_num so no variable bit index is needed.
  always_comb begin
    w_rem = '0;
    w_num = i_dividend;
    w_quo = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_rem = {w_rem[WIDTH-1:0], w_num[WIDTH-1]};
      w_num = {w_num[WIDTH-2:0], 1'b0};
      if (w_rem >= {1'b0, i_divisor}) begin
        w_rem = w_rem - {1'b0, i_divisor};
        w_quo = {w_quo[WIDTH-2:0], 1'b1};
      end else begin
        w_quo = {w_quo[WIDTH-2:0], 1'b0};
      end
    end
    if (i_divisor == '0) begin
      w_quo = DIV_BY_ZERO[WIDTH-1:0];
    end
  end

  assign o_quotient = w_quo;

endmodule

// File: rtl/arith_unit.sv
// Registered unsigned ALU: ADD/SUB/MUL/DIV selected by op_sel, 1-cycle latency.
module arith_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_data_out;

  // Results are sized to WIDTH, so carry and upper product bits drop off.
  assign w_sum  = data_1 + data_2;
  assign w_diff = data_1 - data_2;
  assign w_prod = data_1 * data_2;

  arith_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .i_dividend(data_1),
    .i_divisor (data_2),
    .o_quotient(w_quot)
  );

  // Select the result for the current opcode; every encoding is defined.
  always_comb begin
    w_result = w_sum;
    case (op_e'(op_sel))
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_MUL:  w_result = w_prod;
      OP_DIV:  w_result = w_quot;
      default: w_result = w_sum;
    endcase
  end

  // Output register, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
    end else begin
      r_data_out <= w_result;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit: directed vectors plus a per-cycle model compare.
module tb_arith_unit;

  logic        clk;
  logic        reset;
  logic [15:0] data_1;
  logic [15:0] data_2;
  logic [1:0]  op_sel;
  logic [15:0] data_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q;
  logic        tracking = 1'b0;

  arith_unit #(
    .WIDTH(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_1  (data_1),
    .data_2  (data_2),
    .op_sel  (op_sel),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic from the operation definitions, using wide integers.
  function automatic logic [15:0] model(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    longint unsigned x, y, r;
    x = a;
    y = b;
    case (op)
      2'd0:    r = (x + y) % 65536;
      2'd1:    r = (x + 65536 - y) % 65536;
      2'd2:    r = (x * y) % 65536;
      default: r = (y == 0) ? 65535 : x / y;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output: what the registered result must be given the inputs at the last edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_q = 16'h0000;
    else        exp_q = model(op_sel, data_1, data_2);
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (tracking) chk("cycle", data_out, exp_q);
  end

  // Drive one operation, then check the literal expectation one edge later.
  task automatic apply(input string name, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    @(negedge clk);
    op_sel = op;
    data_1 = a;
    data_2 = b;
    chk({name, "_model"}, model(op, a, b), exp);
    @(posedge clk);
    #1;
    chk(name, data_out, exp);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{"add_7_9",      2'd0, 16'd7,     16'd9,     16'd16},
    '{"add_wrap",     2'd0, 16'hFFFF,  16'h0001,  16'h0000},
    '{"sub_9_4",      2'd1, 16'd9,     16'd4,     16'd5},
    '{"sub_3_5",      2'd1, 16'd3,     16'd5,     16'hFFFE},
    '{"sub_0_0",      2'd1, 16'd0,     16'd0,     16'd0},
    '{"mul_9_9",      2'd2, 16'd9,     16'd9,     16'd81},
    '{"mul_ff_101",   2'd2, 16'h00FF,  16'h0101,  16'hFFFF},
    '{"mul_trunc",    2'd2, 16'h0100,  16'h0100,  16'h0000},
    '{"div_9_2",      2'd3, 16'd9,     16'd2,     16'd4},
    '{"div_2_9",      2'd3, 16'd2,     16'd9,     16'd0},
    '{"div_ffff_1",   2'd3, 16'hFFFF,  16'd1,     16'hFFFF},
    '{"div_5_0",      2'd3, 16'd5,     16'd0,     16'hFFFF},
    '{"div_big",      2'd3, 16'hFFFF,  16'h0100,  16'h00FF},
    '{"b2b_add",      2'd0, 16'd8,     16'd2,     16'd10},
    '{"b2b_sub",      2'd1, 16'd8,     16'd2,     16'd6},
    '{"b2b_mul",      2'd2, 16'd8,     16'd2,     16'd16},
    '{"b2b_div",      2'd3, 16'd8,     16'd2,     16'd4}
  };

  initial begin
    reset  = 1'b1;
    data_1 = '0;
    data_2 = '0;
    op_sel = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset_async", data_out, 16'h0000);
    tracking = 1'b1;

    // Random inputs while held in reset must not reach the output.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_1 = 16'($urandom);
      data_2 = 16'($urandom);
      op_sel = 2'($urandom);
      @(posedge clk);
      #1;
      chk("reset_hold", data_out, 16'h0000);
    end

    // First edge after release loads the current inputs.
    @(negedge clk);
    reset  = 1'b1;
    data_1 = 16'd3;
    data_2 = 16'd4;
    op_sel = 2'd0;
    @(posedge clk);
    #1;
    chk("post_reset", data_out, 16'd7);

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Opcode wiggling between edges must not disturb the registered result.
    apply("glitch_base", 2'd2, 16'd12, 16'd3, 16'd36);
    #1 op_sel = 2'd0;
    #1 op_sel = 2'd3;
    #1;
    chk("glitch_hold", data_out, 16'd36);
    op_sel = 2'd2;

    // Mid-cycle reset clears the output before the next edge.
    apply("mid_add", 2'd0, 16'd8, 16'd2, 16'd10);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset", data_out, 16'h0000);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", data_out, 16'h0000);
    @(negedge clk);
    reset  = 1'b1;
    data_1 = 16'd3;
    data_2 = 16'd4;
    op_sel = 2'd0;
    @(posedge clk);
    #1;
    chk("mid_release", data_out, 16'd7);

    // A short burst of random operations checked by the per-cycle compare.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      data_1 = 16'($urandom);
      data_2 = (i % 5 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      op_sel = 2'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    tracking = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
